// File: rtl/btn_pkg.sv
// btn_pkg: definitions shared by the button event queue.
//   - Event codes reported in data_out[2:0].
//   - Bit positions of the fields in the data_out read word.
//   - Button indices used in the internal pending vector.
//   - Helpers that pick the winning pending button and build its clear mask.
package btn_pkg;

    typedef logic [2:0] evt_code_t;

    localparam evt_code_t EVT_NONE  = 3'd0;
    localparam evt_code_t EVT_UP    = 3'd1;
    localparam evt_code_t EVT_RIGHT = 3'd2;
    localparam evt_code_t EVT_DOWN  = 3'd3;
    localparam evt_code_t EVT_LEFT  = 3'd4;

    // data_out field positions
    localparam int CODE_LSB  = 0;
    localparam int CODE_MSB  = 2;
    localparam int VALID_BIT = 3;
    localparam int COUNT_LSB = 4;
    localparam int COUNT_MSB = 7;
    localparam int OVF_BIT   = 8;

    // Pending-vector bit order. The index order is also the priority order.
    localparam int NUM_BTN = 4;
    localparam int BTN_U   = 0;
    localparam int BTN_R   = 1;
    localparam int BTN_D   = 2;
    localparam int BTN_L   = 3;

    // Return the highest-priority pending button: U > R > D > L.
    function automatic evt_code_t pick_code(input logic [NUM_BTN-1:0] pend);
        evt_code_t code;
        code = EVT_NONE;
        if (pend[BTN_U]) begin
            code = EVT_UP;
        end else if (pend[BTN_R]) begin
            code = EVT_RIGHT;
        end else if (pend[BTN_D]) begin
            code = EVT_DOWN;
        end else if (pend[BTN_L]) begin
            code = EVT_LEFT;
        end
        return code;
    endfunction

    // Return the one-hot pending bit that belongs to an event code.
    function automatic logic [NUM_BTN-1:0] code_mask(input evt_code_t code);
        logic [NUM_BTN-1:0] m;
        m = '0;
        case (code)
            EVT_UP:    m[BTN_U] = 1'b1;
            EVT_RIGHT: m[BTN_R] = 1'b1;
            EVT_DOWN:  m[BTN_D] = 1'b1;
            EVT_LEFT:  m[BTN_L] = 1'b1;
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizer and debouncer for one push-button.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   btn_i   in   raw asynchronous button
//   level_o out  debounced level (registered)
//   rise_o  out  high during the cycle whose edge moves the level from 0 to 1
//
// The raw input passes through two flops. The level flips on the edge where the
// synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
// Any cycle in which the two agree clears the run counter.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 290000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            // cnt_q holds the number of earlier differing cycles. The current
            // cycle completes the run when cnt_q reaches DEBOUNCE_CYCLES-1.
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Combinational from registers only, so the pending bit can be set on the same edge.
    assign rise_o  = level_d & ~level_q;
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/button_event_queue.sv
// button_event_queue: four debounced buttons feeding a register-based FIFO of
// press events. The FIFO is read through one memory-mapped word.
// Ports:
//   clk                     in   system clock (clk_29 domain)
//   reset                   in   synchronous, active-high reset
//   BTNU, BTNR, BTND, BTNL  in   raw asynchronous push-buttons
//   pop                     in   single-cycle read strobe for mapped address 0
//   data_out[31:0]          out  {23'b0, overflow, count[3:0], not_empty, head_code[2:0]}
//   overflow                out  sticky flag, set when an event is dropped
//
// Handshake: pop is a one-cycle strobe. When the FIFO holds at least one entry,
// the head advances on the edge that samples pop. When the FIFO is empty, pop
// does not move the head. Any pop clears overflow unless an event is dropped in
// the same cycle.
module button_event_queue
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 290000,
    parameter int DEPTH           = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        BTNU,
    input  logic        BTNR,
    input  logic        BTND,
    input  logic        BTNL,
    input  logic        pop,
    output logic [31:0] data_out,
    output logic        overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] btn_level;

    assign btn_raw = {BTNL, BTND, BTNR, BTNU};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .btn_i   (btn_raw[i]),
            .level_o (btn_level[i]),
            .rise_o  (btn_rise[i])
        );
    end

    evt_code_t          fifo_q [DEPTH];
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic [3:0]         count_q, count_d;
    logic               overflow_q, overflow_d;

    evt_code_t          sel_code;
    logic               push, push_ok, pop_ok, drop, full, empty;

    always_comb begin
        sel_code = pick_code(pending_q);
        push     = (sel_code != EVT_NONE);
        full     = (count_q == DEPTH_CNT);
        empty    = (count_q == 4'd0);
        pop_ok   = pop & ~empty;
        // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
        push_ok  = push & (~full | pop_ok);
        drop     = push & full & ~pop_ok;

        // The selected bit is cleared whether its event is stored or dropped.
        // A rise can only occur while the stored level is still low.
        pending_d = (pending_q & ~code_mask(sel_code)) | (btn_rise & ~btn_level);

        wptr_d = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop_ok  ? rptr_q + 1'b1 : rptr_q;

        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (pop) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset. Entries are visible only through count_q, which is reset.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            fifo_q[wptr_q] <= sel_code;
        end
    end

    always_comb begin
        data_out                      = '0;
        data_out[CODE_MSB:CODE_LSB]   = empty ? EVT_NONE : fifo_q[rptr_q];
        data_out[VALID_BIT]           = ~empty;
        data_out[COUNT_MSB:COUNT_LSB] = count_q;
        data_out[OVF_BIT]             = overflow_q;
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_button_event_queue.sv
module tb_button_event_queue;

    localparam int D      = 4;
    localparam int DEPTH  = 8;
    localparam int SYNC   = 2;
    localparam int SETTLE = SYNC + D + 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        BTNU, BTNR, BTND, BTNL;
    logic        pop;
    logic [31:0] data_out;
    logic        overflow;

    int n_vec = 0;
    int n_bad = 0;

    logic [2:0] exp_q[$];
    logic       exp_ovf = 1'b0;

    always #5 clk = ~clk;

    button_event_queue #(
        .DEBOUNCE_CYCLES(D),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .BTNU     (BTNU),
        .BTNR     (BTNR),
        .BTND     (BTND),
        .BTNL     (BTNL),
        .pop      (pop),
        .data_out (data_out),
        .overflow (overflow)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Build the read word expected from the model queue and the overflow flag.
    function automatic logic [31:0] model_word();
        logic [31:0] w;
        int n;
        n = exp_q.size();
        w = '0;
        if (n > 0) begin
            w[2:0] = exp_q[0];
            w[3]   = 1'b1;
        end
        w[7:4] = 4'(n);
        w[8]   = exp_ovf;
        return w;
    endfunction

    // A new event either fits in the queue or is dropped and sets overflow.
    task automatic push_expected(input logic [2:0] code);
        if (exp_q.size() < DEPTH) exp_q.push_back(code);
        else exp_ovf = 1'b1;
    endtask

    task automatic check_state(input string name);
        check(name, data_out, model_word());
        check({name, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input logic [3:0] m);
        BTNU = m[0];
        BTNR = m[1];
        BTND = m[2];
        BTNL = m[3];
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step(1);
        pop = 1'b0;
        exp_ovf = 1'b0;
    endtask

    // Optional bounce: each high run and each low run is shorter than D cycles.
    // Then hold, release and wait until the block is idle again.
    task automatic press_mask(input logic [3:0] m, input bit bounce);
        if (bounce) begin
            repeat ($urandom_range(1, 3)) begin
                set_btn(m);
                step($urandom_range(1, D - 1));
                set_btn(4'b0000);
                step($urandom_range(1, D - 1));
            end
        end
        set_btn(m);
        // Simultaneous presses leave the queue in U, R, D, L order.
        for (int i = 0; i < 4; i++) begin
            if (m[i]) push_expected(3'(i + 1));
        end
        step(SETTLE);
        set_btn(4'b0000);
        step(SETTLE);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b0 && pop === 1'b1) begin
            check("pop_valid", 32'(data_out[3]), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("pop_head", 32'(data_out[2:0]), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] m;
        int found;
        int waited;

        reset = 1'b1;
        pop   = 1'b0;
        set_btn(4'b0000);
        step(3);
        check("reset_word", data_out, 32'h0);
        check("reset_ovf", 32'(overflow), 32'h0);
        reset = 1'b0;
        step(2);
        check_state("idle");

        // Bouncing shorter than the debounce window produces no event.
        for (int i = 0; i < 30; i++) begin
            BTNU = (i < 20) ? 1'((i / 2) % 2) : 1'b0;
            step(1);
            check("toggle_idle", data_out, 32'h0);
        end

        // A single right press: latency bound and no event on release.
        BTNR = 1'b1;
        push_expected(3'd2);
        found  = 0;
        waited = 0;
        while (waited < 8 && found == 0) begin
            step(1);
            waited++;
            if (data_out == 32'h0000_001A) found = 1;
        end
        check("r_latency", 32'(found), 32'd1);
        step(10 - waited);
        BTNR = 1'b0;
        step(SETTLE + 4);
        check("r_release", data_out, 32'h0000_001A);
        check_state("r_release_model");
        do_pop();
        check_state("r_popped");

        // Up and left pressed on the same cycle.
        press_mask(4'b1001, 1'b0);
        check_state("ul_pair");
        check("ul_count", 32'(data_out[7:4]), 32'd2);
        do_pop();
        check_state("ul_pop1");
        do_pop();
        check("ul_empty", data_out, 32'h0);

        // Random presses with bounce and random pops.
        repeat (12) begin
            m = 4'($urandom_range(1, 15));
            while (exp_q.size() + $countones(m) > DEPTH) do_pop();
            press_mask(m, 1'b1);
            check_state("rand_press");
            repeat ($urandom_range(0, exp_q.size())) do_pop();
            check_state("rand_pop");
        end
        while (exp_q.size() > 0) do_pop();
        do_pop();
        check_state("empty_pop");
        check("empty_count", 32'(data_out[7:4]), 32'd0);

        // Nine presses with no pops: the ninth event is dropped.
        for (int i = 0; i < 9; i++) begin
            press_mask(4'(1 << (i % 4)), 1'b0);
        end
        check_state("ovf_full");
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_bit", 32'(data_out[8]), 32'd1);
        do_pop();
        check_state("ovf_popped");
        check("ovf_count7", 32'(data_out[7:4]), 32'd7);

        // Fill to DEPTH, then pop on the exact cycle an enqueue lands.
        press_mask(4'b0010, 1'b0);
        check_state("full_again");
        set_btn(4'b0001);
        step(SYNC + D);
        do_pop();
        push_expected(3'd1);
        step(SETTLE - SYNC - D - 1);
        set_btn(4'b0000);
        step(SETTLE);
        check_state("full_pop_push");
        check("full_pop_count", 32'(data_out[7:4]), 32'd8);

        // Reset with three entries queued while down is held.
        while (exp_q.size() > 0) do_pop();
        press_mask(4'b0011, 1'b0);
        set_btn(4'b0100);
        push_expected(3'd3);
        step(SETTLE);
        check_state("pre_reset");
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        check("reset_clear", data_out, 32'h0);
        push_expected(3'd3);
        step(SETTLE);
        check_state("held_after_reset");
        set_btn(4'b0000);
        step(SETTLE);
        check_state("held_one_event");
        do_pop();
        check_state("final_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
